// File: rtl/myy_op_sched.sv
// Round-robin scheduler sharing one Booth-multiplier control unit among R requesters.
// Each operation: grant, pulse sno, wait for sko (or watchdog timeout), pulse done to the winner.
module myy_op_sched #(
  parameter int R   = 4,
  parameter int TMO = 32,
  parameter int SW  = 2
) (
  input  logic          clk,
  input  logic          set_n,
  input  logic [R-1:0]  req,
  output logic [R-1:0]  gnt,
  output logic [SW-1:0] sel,
  output logic          sno,
  input  logic          sko,
  output logic [R-1:0]  done,
  output logic          busy,
  output logic          tmo_err,
  input  logic          err_clr
);

  localparam int CW = $clog2(TMO + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [SW-1:0] win;
  logic          found;
  logic [SW-1:0] ptr_nxt;

  // Scan ptr, ptr+1, ..., wrapping; first set bit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (!found && req[(int'(ptr) + i) % R]) begin
        found = 1'b1;
        win   = SW'((int'(ptr) + i) % R);
      end
    end
  end

  assign ptr_nxt = (sel == SW'(R - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      sel     <= '0;
      gnt     <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (err_clr) tmo_err <= 1'b0;
      case (state)
        S_IDLE: if (|req) begin
          sel   <= win;
          gnt   <= {{(R-1){1'b0}}, 1'b1} << win;
          state <= S_START;
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Saturating count; sko beats timeout, timeout set beats err_clr.
          if (cnt != CW'(TMO)) cnt <= cnt + 1'b1;
          if (sko) state <= S_DONE;
          else if (cnt == CW'(TMO - 1)) begin
            tmo_err <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: begin
          gnt   <= '0;
          ptr   <= ptr_nxt;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign sno  = (state == S_START);
  assign busy = (state != S_IDLE);

  for (genvar i = 0; i < R; i++) begin : g_done
    assign done[i] = (state == S_DONE) && (sel == SW'(i));
  end

endmodule

// File: tb/tb_myy_op_sched.sv
// Scoreboard bench for myy_op_sched: predicted winners are queued at request time
// and checked against the done pulses the DUT returns.
module tb_myy_op_sched;
  localparam int R = 4, TMO = 32, SW = 2;

  logic          clk = 1'b0;
  logic          set_n = 1'b0;
  logic [R-1:0]  req = '0;
  logic [R-1:0]  gnt;
  logic [SW-1:0] sel;
  logic          sno;
  logic          sko = 1'b0;
  logic [R-1:0]  done;
  logic          busy;
  logic          tmo_err;
  logic          err_clr = 1'b0;

  myy_op_sched #(.R(R), .TMO(TMO), .SW(SW)) dut (
    .clk(clk), .set_n(set_n), .req(req), .gnt(gnt), .sel(sel), .sno(sno),
    .sko(sko), .done(done), .busy(busy), .tmo_err(tmo_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0, err_cnt = 0;
  int sno_cnt = 0, done_cnt = 0;
  int mptr = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [R-1:0] r, input int p);
    for (int i = 0; i < R; i++)
      if (r[(p + i) % R]) return (p + i) % R;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Done monitor: pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    if (set_n) begin
      if (sno) sno_cnt++;
      if (done != '0) begin
        done_cnt++;
        if (exp_q.size() == 0) chk("done_unexp", 32'(done), 32'h0);
        else begin
          automatic int e = exp_q.pop_front();
          chk("done", 32'(done), 32'(1 << e));
        end
      end
    end
  end

  task automatic do_reset();
    set_n = 1'b0;
    req = '0; sko = 1'b0; err_clr = 1'b0;
    tick();
    set_n = 1'b1;
    mptr = 0;
  endtask

  // One full operation: predicts winner, runs to DONE, leaves req=next_req, ends in IDLE.
  task automatic op(input logic [R-1:0] r, input int lat, input bit drop, input logic [R-1:0] next_req);
    automatic int e = rr_pick(r, mptr);
    automatic bit got = 1'b0;
    exp_q.push_back(e);
    req = r;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (sno) got = 1'b1;
    end
    if (!got) begin
      chk("sno_timeout", 32'(sno), 32'h1);
      return;
    end
    chk("gnt", 32'(gnt), 32'(1 << e));
    chk("sel", 32'(sel), 32'(e));
    tick();
    chk("sno_1cyc", 32'(sno), 32'h0);
    if (drop) req[e] = 1'b0;
    repeat (lat) tick();
    sko = 1'b1;
    tick();
    sko = 1'b0;
    chk("gnt_in_done", 32'(gnt), 32'(1 << e));
    req = next_req;
    tick();
    chk("gnt_idle", 32'(gnt), 32'h0);
    chk("busy_idle", 32'(busy), 32'h0);
    chk("done_1cyc", 32'(done), 32'h0);
    mptr = (e + 1) % R;
  endtask

  initial begin
    #2;
    chk("rst_gnt",  32'(gnt),  32'h0);
    chk("rst_sel",  32'(sel),  32'h0);
    chk("rst_sno",  32'(sno),  32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tmo",  32'(tmo_err), 32'h0);
    do_reset();

    // Single requester.
    op(4'b0100, 4, 1'b0, 4'b0000);

    // All held high: order 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < 5; k++) op(4'b1111, 4, 1'b0, 4'b1111);
    req = '0;
    tick();
    chk("sno_eq_done", 32'(sno_cnt), 32'(done_cnt));

    // ptr=2 after serving 1, then req=1011 -> 3,0,1.
    do_reset();
    op(4'b0010, 2, 1'b0, 4'b0000);
    op(4'b1011, 2, 1'b0, 4'b1011);
    op(4'b1011, 2, 1'b0, 4'b1011);
    op(4'b1011, 2, 1'b0, 4'b0000);

    // Watchdog: no sko.
    do_reset();
    exp_q.push_back(0);
    req = 4'b0001;
    tick();                       // START
    chk("tmo_sno", 32'(sno), 32'h1);
    tick();                       // entered WAIT
    repeat (31) tick();
    chk("tmo_early", 32'(tmo_err), 32'h0);
    chk("busy_wait", 32'(busy), 32'h1);
    tick();
    chk("tmo_set", 32'(tmo_err), 32'h1);
    chk("tmo_done", 32'(done), 32'h1);
    req = '0;
    tick();
    chk("tmo_idle", 32'(busy), 32'h0);
    mptr = 1;
    op(4'b0010, 3, 1'b0, 4'b0000);
    chk("tmo_sticky", 32'(tmo_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_clr", 32'(tmo_err), 32'h0);

    // Async reset mid-WAIT; no done for the aborted op.
    do_reset();
    req = 4'b0001;
    tick(); tick(); tick();
    chk("pre_abort_busy", 32'(busy), 32'h1);
    #2 set_n = 1'b0;
    #1;
    chk("abort_gnt",  32'(gnt),  32'h0);
    chk("abort_sno",  32'(sno),  32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    req = '0;
    tick();
    set_n = 1'b1;
    mptr = 0;
    sko = 1'b1;
    tick();
    sko = 1'b0;
    chk("stray_busy", 32'(busy), 32'h0);
    op(4'b0001, 3, 1'b0, 4'b0000);

    // Winner drops req during WAIT; stray sko while IDLE.
    op(4'b0100, 3, 1'b1, 4'b0000);
    sko = 1'b1;
    tick();
    sko = 1'b0;
    chk("stray2_busy", 32'(busy), 32'h0);
    chk("stray2_done", 32'(done), 32'h0);
    chk("stray2_gnt",  32'(gnt),  32'h0);
    tick();

    chk("q_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end
endmodule
